binary_gray_counter: RTL and testbench

BINARY_GRAY_COUNTER -- requirements
Module: binary_gray_counter

---
 rtl/binary_gray_counter_pkg.sv | 23 ++
 rtl/binary_gray_counter_to_gray.sv | 14 +
 rtl/binary_gray_counter.sv | 63 ++++++
 tb/tb_binary_gray_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/binary_gray_counter_pkg.sv
// Shared width definition and binary/Gray conversion helpers for the
// counter and the gray-to-binary decoder.
package binary_gray_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned MAX_WIDTH     = 16;

    // Binary to reflected Gray code; narrower callers zero-extend.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/binary_gray_counter_to_gray.sv
// Combinational binary-to-Gray converter feeding the gray register.
module binary_to_gray
    import binary_gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Zero-extend into the shared helper and keep the low WIDTH bits.
    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/binary_gray_counter.sv
// Up/down modulo-2^WIDTH counter with registered binary and Gray outputs
// and a one-cycle wrap pulse.
module binary_gray_counter
    import binary_gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;
    logic [WIDTH:0]   step_ext;

    // Next binary value and wrap: load beats en; carry/borrow only forms wrap.
    always_comb begin
        bin_next  = binary;
        wrap_next = 1'b0;
        step_ext  = '0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                step_ext = {1'b0, binary} + (WIDTH+1)'(1);
            end else begin
                step_ext = {1'b0, binary} - (WIDTH+1)'(1);
            end
            bin_next  = step_ext[WIDTH-1:0];
            wrap_next = step_ext[WIDTH];
        end
    end

    // Gray register is fed from the next binary value, not the output port.
    binary_to_gray #(
        .WIDTH (WIDTH)
    ) u_binary_to_gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // Output registers, updated together so binary and gray never skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            binary <= '0;
            gray   <= '0;
            wrap   <= 1'b0;
        end else begin
            binary <= bin_next;
            gray   <= gray_next;
            wrap   <= wrap_next;
        end
    end

endmodule

// File: tb/tb_binary_gray_counter.sv
// Directed and randomized self-checking bench for binary_gray_counter.
module tb_binary_gray_counter;
    import binary_gray_counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_bin;
    logic [3:0] binary;
    logic [3:0] gray;
    logic       wrap;

    int total;
    int bad;

    binary_gray_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .binary   (binary),
        .gray     (gray),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] b, input logic [3:0] g,
                             input logic w);
        check4({tag, ".binary"}, binary, b);
        check4({tag, ".gray"}, gray, g);
        check4({tag, ".wrap"}, {3'b000, wrap}, {3'b000, w});
    endtask

    // Drive one cycle of inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lb);
        en = e; up = u; load = l; load_bin = lb;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_seq [0:16];
    logic [3:0] m;
    logic [3:0] m_gray_prev;
    logic       w_exp;
    logic       r_en, r_up, r_load;
    logic [3:0] r_lb;

    initial begin
        total = 0;
        bad   = 0;
        gray_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                     4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011,
                     4'b1001, 4'b1000, 4'b0000};

        // Reset held: outputs zero before any edge and regardless of en/load.
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'd0;
        #2;
        check_all("rst_async", 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'd5);
        check_all("rst_hold_load", 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("rst_hold_en", 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("idle_after_rst", 4'd0, 4'd0, 1'b0);

        // Full up sweep with wrap only after 1111 -> 0000.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0);
            check_all($sformatf("up_sweep%0d", i), 4'((i + 1) % 16), gray_seq[i+1], i == 15);
        end

        // Down across zero, then one more down step.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check_all("down_wrap", 4'b1111, 4'b1000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check_all("down_after", 4'b1110, 4'b1001, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("hold", 4'b1110, 4'b1001, 1'b0);

        // Direction reversal takes effect on the very next edge.
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("dir_up", 4'b1111, 4'b1000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check_all("dir_down", 4'b1110, 4'b1001, 1'b0);

        // Load, then load together with en (load wins).
        step(1'b0, 1'b1, 1'b1, 4'b1010);
        check_all("load_a", 4'b1010, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b0011);
        check_all("load_wins", 4'b0011, 4'b0010, 1'b0);

        // Load of all-ones does not pulse wrap; counting past it does.
        step(1'b0, 1'b1, 1'b1, 4'b1111);
        check_all("load_f", 4'b1111, 4'b1000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("load_f_up", 4'b0000, 4'b0000, 1'b1);

        // Pending wrap is killed by an asynchronous mid-cycle reset.
        #2; rst = 1'b1; #1;
        check_all("rst_kills_wrap", 4'd0, 4'd0, 1'b0);
        #1; rst = 1'b0;

        // Count to 0110, reset between edges, then first up step gives 1/1.
        step(1'b0, 1'b1, 1'b1, 4'b0101);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("to_six", 4'b0110, 4'b0101, 1'b0);
        #2; rst = 1'b1; #1;
        check_all("rst_mid", 4'd0, 4'd0, 1'b0);
        #1; rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check_all("first_up", 4'b0001, 4'b0001, 1'b0);

        // Loop-back through the gray-to-binary decoder for all 16 values.
        step(1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 16; i++) begin
            check4($sformatf("loop_bin%0d", i), binary, 4'(i));
            check4($sformatf("loop_dec%0d", i), 4'(gray2bin(16'(gray))), 4'(i));
            step(1'b1, 1'b1, 1'b0, 4'd0);
        end

        // Randomized run against a reference model.
        step(1'b0, 1'b1, 1'b1, 4'd0);
        m = 4'd0;
        for (int i = 0; i < 1000; i++) begin
            r_en   = 1'($urandom_range(0, 1));
            r_up   = 1'($urandom_range(0, 1));
            r_load = ($urandom_range(0, 7) == 0);
            r_lb   = 4'($urandom);
            m_gray_prev = m ^ (m >> 1);
            w_exp = 1'b0;
            if (r_load) begin
                m = r_lb;
            end else if (r_en) begin
                w_exp = r_up ? (m == 4'hF) : (m == 4'h0);
                m = r_up ? m + 4'd1 : m - 4'd1;
            end
            step(r_en, r_up, r_load, r_lb);
            check4("rnd_bin", binary, m);
            check4("rnd_gray", gray, binary ^ (binary >> 1));
            check4("rnd_wrap", {3'b000, wrap}, {3'b000, w_exp});
            if (!r_load && r_en) begin
                check4("rnd_1bit", 4'($countones(gray ^ m_gray_prev)), 4'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
